// File: rtl/pkt_tx.sv
// Store-and-forward packet transmitter: buffers one packet, then replays it on an Avalon-ST source.
// Overflow policy is selected by PKT_TX_OVERFLOW_DROP_EN (undefined: truncate and send; defined: drop packet).
module pkt_tx #(
  parameter int DWIDTH      = 8,
  parameter int MAX_PKT_LEN = 1024
) (
  input  logic              clk_i,
  input  logic              srst_i,
  input  logic [DWIDTH-1:0] wr_data_i,
  input  logic              wr_last_i,
  input  logic              wr_valid_i,
  output logic              wr_ready_o,
  input  logic              src_ready_i,
  output logic [DWIDTH-1:0] src_data_o,
  output logic              src_startofpacket_o,
  output logic              src_endofpacket_o,
  output logic              src_valid_o,
  output logic              ovf_o
);

  localparam int AW = $clog2(MAX_PKT_LEN);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] C_LAST_IDX = CW'(MAX_PKT_LEN - 1);
  localparam logic [CW-1:0] C_ONE      = CW'(1);

  typedef enum logic [1:0] {LOAD, PREP, SEND} state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [DWIDTH-1:0] r_mem [MAX_PKT_LEN];
  logic [DWIDTH-1:0] r_rd_data;
  logic [CW-1:0]     r_wr_addr;
  logic [CW-1:0]     r_len;
  logic [CW-1:0]     r_rd_addr;
  logic              r_ovf;
  logic [AW-1:0]     w_rd_idx;
  logic              w_accept;
  logic              w_full;
  logic              w_pkt_end;
  logic              w_ovf_event;
  logic              w_addr_clr;
  logic              w_addr_inc;
  logic              w_xfer;
  logic              w_eop;

  assign w_accept = wr_valid_i && wr_ready_o;
  assign w_full   = (r_wr_addr == C_LAST_IDX);

`ifdef PKT_TX_OVERFLOW_DROP_EN
  logic r_drop;
  logic w_drop_start;

  // Once the buffer fills without a last marker, swallow words until the packet ends.
  assign w_drop_start = w_accept && !wr_last_i && w_full && !r_drop;
  assign w_pkt_end    = w_accept && wr_last_i && !r_drop;
  assign w_ovf_event  = w_accept && wr_last_i && r_drop;
  assign w_addr_clr   = w_drop_start || w_ovf_event;
  assign w_addr_inc   = w_accept && !r_drop;

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      r_drop <= 1'b0;
    end else if (w_drop_start) begin
      r_drop <= 1'b1;
    end else if (w_ovf_event) begin
      r_drop <= 1'b0;
    end
  end
`else
  // A full buffer forces the current word to close the packet.
  assign w_pkt_end   = w_accept && (wr_last_i || w_full);
  assign w_ovf_event = w_accept && !wr_last_i && w_full;
  assign w_addr_clr  = 1'b0;
  assign w_addr_inc  = w_accept;
`endif

  assign w_xfer = (r_state == SEND) && src_ready_i;
  assign w_eop  = (r_rd_addr == (r_len - C_ONE));

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      r_state <= LOAD;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      LOAD:    if (w_pkt_end) w_state_next = PREP;
      PREP:    w_state_next = SEND;
      SEND:    if (w_xfer && w_eop) w_state_next = LOAD;
      default: w_state_next = LOAD;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      r_wr_addr <= '0;
      r_len     <= '0;
      r_rd_addr <= '0;
      r_ovf     <= 1'b0;
    end else begin
      r_ovf <= w_ovf_event;
      if (w_pkt_end) begin
        r_len     <= r_wr_addr + C_ONE;
        r_wr_addr <= '0;
      end else if (w_addr_clr) begin
        r_wr_addr <= '0;
      end else if (w_addr_inc) begin
        r_wr_addr <= r_wr_addr + C_ONE;
      end
      if (r_state == PREP) begin
        r_rd_addr <= '0;
      end else if (w_xfer) begin
        r_rd_addr <= r_rd_addr + C_ONE;
      end
    end
  end

  // Read address runs one word ahead of a transfer so the output register never bubbles.
  always_comb begin
    w_rd_idx = r_rd_addr[AW-1:0];
    if (r_state == PREP) begin
      w_rd_idx = '0;
    end else if (w_xfer) begin
      w_rd_idx = r_rd_addr[AW-1:0] + AW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_accept) begin
      r_mem[r_wr_addr[AW-1:0]] <= wr_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      r_rd_data <= '0;
    end else begin
      r_rd_data <= r_mem[w_rd_idx];
    end
  end

  assign wr_ready_o          = (r_state == LOAD) && !srst_i;
  assign src_valid_o         = (r_state == SEND) && !srst_i;
  assign src_startofpacket_o = src_valid_o && (r_rd_addr == '0);
  assign src_endofpacket_o   = src_valid_o && w_eop;
  assign src_data_o          = srst_i ? '0 : r_rd_data;
  assign ovf_o               = r_ovf && !srst_i;

endmodule

// File: tb/tb_pkt_tx.sv
// Directed/randomized bench for pkt_tx: packet-level reference model, stall stability and overflow checks.
`timescale 1ns/1ps
module tb_pkt_tx;
  localparam int DW   = 8;
  localparam int MAXL = 1024;

  logic          clk_i = 1'b0;
  logic          srst_i;
  logic [DW-1:0] wr_data_i;
  logic          wr_last_i;
  logic          wr_valid_i;
  logic          wr_ready_o;
  logic          src_ready_i;
  logic [DW-1:0] src_data_o;
  logic          src_startofpacket_o;
  logic          src_endofpacket_o;
  logic          src_valid_o;
  logic          ovf_o;

  always #5 clk_i = ~clk_i;

  pkt_tx #(.DWIDTH(DW), .MAX_PKT_LEN(MAXL)) dut (
    .clk_i(clk_i), .srst_i(srst_i), .wr_data_i(wr_data_i), .wr_last_i(wr_last_i),
    .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready_o), .src_ready_i(src_ready_i),
    .src_data_o(src_data_o), .src_startofpacket_o(src_startofpacket_o),
    .src_endofpacket_o(src_endofpacket_o), .src_valid_o(src_valid_o), .ovf_o(ovf_o)
  );

  typedef struct {
    logic [DW-1:0] d;
    bit            sop;
    bit            eop;
  } xfer_t;

  xfer_t         exp_q[$];
  logic [DW-1:0] pkt[$];
  int checks = 0;
  int failures = 0;
  int n_xfer = 0;
  int ovf_seen = 0;
  int ovf_exp = 0;
  bit rand_ready = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // Reference: split the loaded word list into the packets the sink should see.
  task automatic model_pkt();
    int n = pkt.size();
`ifdef PKT_TX_OVERFLOW_DROP_EN
    if (n > MAXL) begin
      ovf_exp++;
      return;
    end
    for (int i = 0; i < n; i++) exp_q.push_back('{d: pkt[i], sop: (i == 0), eop: (i == n - 1)});
`else
    int start;
    int len;
    start = 0;
    while (start < n) begin
      len = (n - start > MAXL) ? MAXL : n - start;
      if (len == MAXL && start + len < n) ovf_exp++;
      for (int i = 0; i < len; i++)
        exp_q.push_back('{d: pkt[start + i], sop: (i == 0), eop: (i == len - 1)});
      start += len;
    end
`endif
  endtask

  task automatic handshake();
    int  t;
    bit  rdy;
    t = 0;
    do begin
      @(negedge clk_i);
      rdy = wr_ready_o;
      @(posedge clk_i); #1;
      t++;
    end while (!rdy && t < 5000);
    chk("load_handshake", 32'(rdy), 1);
  endtask

  task automatic load_pkt(input bit gaps);
    model_pkt();
    for (int i = 0; i < pkt.size(); i++) begin
      if (gaps) begin
        int g = $urandom_range(0, 2);
        repeat (g) begin
          wr_valid_i = 1'b0;
          wr_data_i  = 8'($urandom);
          wr_last_i  = 1'($urandom);
          @(posedge clk_i); #1;
        end
      end
      wr_valid_i = 1'b1;
      wr_data_i  = pkt[i];
      wr_last_i  = (i == pkt.size() - 1);
      handshake();
    end
    wr_valid_i = 1'b0;
    wr_last_i  = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 20000) begin
      @(negedge clk_i);
      t++;
    end
    chk("drain_pending", 32'(exp_q.size()), 0);
    @(posedge clk_i); #1;
  endtask

  task automatic rand_pkt(input int n);
    pkt.delete();
    for (int i = 0; i < n; i++) pkt.push_back(8'($urandom));
  endtask

  initial begin
    src_ready_i = 1'b1;
    forever begin
      @(posedge clk_i); #1;
      src_ready_i = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Sink monitor: scoreboard each transfer, hold-stable checks during stalls, count ovf pulses.
  initial begin
    logic          pv, pr, psop, peop, prst;
    logic [DW-1:0] pd;
    xfer_t         e;
    pv = 0; pr = 0; psop = 0; peop = 0; prst = 1; pd = '0;
    forever begin
      @(negedge clk_i);
      if (!srst_i && !prst && pv && !pr) begin
        chk("stall_valid", 32'(src_valid_o), 1);
        chk("stall_data", 32'(src_data_o), 32'(pd));
        chk("stall_sop", 32'(src_startofpacket_o), 32'(psop));
        chk("stall_eop", 32'(src_endofpacket_o), 32'(peop));
      end
      if (src_valid_o !== 1'b1) begin
        chk("idle_sop", 32'(src_startofpacket_o), 0);
        chk("idle_eop", 32'(src_endofpacket_o), 0);
      end
      if (ovf_o === 1'b1) ovf_seen++;
      if (!srst_i && src_valid_o === 1'b1 && src_ready_i === 1'b1) begin
        checks++;
        assert (exp_q.size() > 0) else begin
          failures++;
          $error("FAIL unexpected_xfer observed=0x%0h expected=no_transfer", src_data_o);
        end
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("xfer_data", 32'(src_data_o), 32'(e.d));
          chk("xfer_sop", 32'(src_startofpacket_o), 32'(e.sop));
          chk("xfer_eop", 32'(src_endofpacket_o), 32'(e.eop));
        end
        n_xfer++;
      end
      pv = src_valid_o; pr = src_ready_i; pd = src_data_o;
      psop = src_startofpacket_o; peop = src_endofpacket_o; prst = srst_i;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    int ovf_before;
    int t;
    srst_i = 1'b1; wr_valid_i = 1'b0; wr_data_i = '0; wr_last_i = 1'b0;

    // Reset state
    @(posedge clk_i); #1;
    @(negedge clk_i);
    chk("rst_wr_ready", 32'(wr_ready_o), 0);
    chk("rst_valid", 32'(src_valid_o), 0);
    chk("rst_sop", 32'(src_startofpacket_o), 0);
    chk("rst_eop", 32'(src_endofpacket_o), 0);
    chk("rst_ovf", 32'(ovf_o), 0);
    chk("rst_data", 32'(src_data_o), 0);
    @(posedge clk_i); #1;
    srst_i = 1'b0;
    @(negedge clk_i);
    chk("post_rst_ready", 32'(wr_ready_o), 1);
    @(posedge clk_i); #1;

    // 10 words 0x0A..0x01, full-rate sink: latency and back-to-back burst
    pkt.delete();
    for (int i = 0; i < 10; i++) pkt.push_back(8'(10 - i));
    load_pkt(1'b0);
    @(negedge clk_i);
    chk("prep_valid", 32'(src_valid_o), 0);
    chk("prep_wr_ready", 32'(wr_ready_o), 0);
    @(negedge clk_i);
    chk("first_valid", 32'(src_valid_o), 1);
    chk("first_sop", 32'(src_startofpacket_o), 1);
    chk("first_data", 32'(src_data_o), 32'h0A);
    for (int i = 1; i < 10; i++) begin
      @(negedge clk_i);
      chk("burst_valid", 32'(src_valid_o), 1);
    end
    @(negedge clk_i);
    chk("burst_ret_ready", 32'(wr_ready_o), 1);
    chk("burst_ret_valid", 32'(src_valid_o), 0);
    @(posedge clk_i); #1;

    // Single-word packet
    pkt.delete();
    pkt.push_back(8'h5C);
    load_pkt(1'b0);
    @(negedge clk_i);
    chk("one_prep_valid", 32'(src_valid_o), 0);
    @(negedge clk_i);
    chk("one_valid", 32'(src_valid_o), 1);
    chk("one_sop", 32'(src_startofpacket_o), 1);
    chk("one_eop", 32'(src_endofpacket_o), 1);
    chk("one_data", 32'(src_data_o), 32'h5C);
    @(negedge clk_i);
    chk("one_ret_ready", 32'(wr_ready_o), 1);
    @(posedge clk_i); #1;

    // 1023 random words, random load gaps and sink stalls
    rand_ready = 1'b1;
    rand_pkt(1023);
    load_pkt(1'b1);
    drain();

    // 1030 words with last on word 1030: overflow handling
    ovf_before = ovf_seen;
    pkt.delete();
    for (int i = 0; i < 1030; i++) pkt.push_back(8'(i));
    load_pkt(1'b0);
    drain();
    repeat (3) @(negedge clk_i);
    chk("ovf_1030_pulses", 32'(ovf_seen - ovf_before), 1);
    @(posedge clk_i); #1;
    rand_pkt(5);
    load_pkt(1'b1);
    drain();

    // Exactly MAX_PKT_LEN words, last on final word: no overflow
    ovf_before = ovf_seen;
    rand_pkt(MAXL);
    load_pkt(1'b0);
    drain();
    chk("ovf_full_none", 32'(ovf_seen - ovf_before), 0);

    // Reset after 3 of 8 words transmitted
    rand_ready = 1'b0;
    @(posedge clk_i); #1;
    base = n_xfer;
    rand_pkt(8);
    load_pkt(1'b0);
    t = 0;
    do begin
      @(posedge clk_i); #2;
      t++;
    end while (n_xfer < base + 3 && t < 100);
    chk("rst_mid_xfers", 32'(n_xfer - base), 3);
    srst_i = 1'b1;
    exp_q.delete();
    @(negedge clk_i);
    chk("rst_mid_valid", 32'(src_valid_o), 0);
    chk("rst_mid_eop", 32'(src_endofpacket_o), 0);
    @(posedge clk_i); #1;
    srst_i = 1'b0;
    @(negedge clk_i);
    chk("rst_after_valid", 32'(src_valid_o), 0);
    chk("rst_after_ready", 32'(wr_ready_o), 1);
    @(posedge clk_i); #1;
    rand_pkt(4);
    load_pkt(1'b1);
    drain();

    chk("ovf_total", 32'(ovf_seen), 32'(ovf_exp));
    chk("final_pending", 32'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
